// File: rtl/rom_word_fetcher_pkg.sv
// rom_word_fetcher_pkg: shared FSM states, lane width and lane-offset helper
package rom_word_fetcher_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
  localparam int LANE_W = 8;
  function automatic int lane_lsb(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction
endpackage

// File: rtl/rom_word_fetcher.sv
// rom_word_fetcher: issues pipelined byte reads to a registered ROM and assembles a little-endian word
module rom_word_fetcher
  import rom_word_fetcher_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = LANE_W,
  parameter int WORD_BYTES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         req_ready,
  output logic                         rsp_valid,
  output logic [WORD_BYTES*DATA_W-1:0] rsp_data,
  input  logic                         rsp_ready,
  output logic                         rom_enable,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [DATA_W-1:0]            rom_data
);
  localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);
  state_t                       state_q, state_d;
  logic [ADDR_W-1:0]            base_q, base_d;
  logic [CNT_W-1:0]             issue_q, issue_d, cap_q, cap_d;
  logic                         cap_en_q, cap_en_d, ready_q;
  logic [WORD_BYTES*DATA_W-1:0] data_q, data_d;
  assign req_ready  = ready_q;
  assign rsp_valid  = state_q == RESP;
  assign rsp_data   = data_q;
  assign rom_enable = state_q == FETCH;
  assign rom_addr   = base_q + ADDR_W'(issue_q);
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    issue_d  = issue_q;
    cap_d    = cap_q;
    cap_en_d = cap_en_q;
    data_d   = data_q;
    case (state_q)
      IDLE: if (req_valid && ready_q) begin
        state_d  = FETCH;
        base_d   = req_addr;
        issue_d  = '0;
        cap_d    = '0;
        cap_en_d = 1'b0;
        data_d   = '0;
      end
      FETCH: begin
        issue_d  = (issue_q == LAST) ? issue_q : issue_q + 1'b1;
        // ROM output lags the address by one cycle, so capture trails issue
        cap_en_d = 1'b1;
        if (cap_en_q) begin
          for (int i = 0; i < WORD_BYTES; i++)
            if (cap_q == CNT_W'(i)) data_d[lane_lsb(i, DATA_W) +: DATA_W] = rom_data;
          cap_d   = cap_q + 1'b1;
          state_d = (cap_q == LAST) ? RESP : FETCH;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      issue_q  <= '0;
      cap_q    <= '0;
      cap_en_q <= 1'b0;
      data_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      issue_q  <= issue_d;
      cap_q    <= cap_d;
      cap_en_q <= cap_en_d;
      data_q   <= data_d;
      ready_q  <= state_d == IDLE;
    end
  end
endmodule

// File: tb/tb_rom_word_fetcher.sv
// tb_rom_word_fetcher: scoreboard and table-driven bench for 2-byte and 4-byte fetchers
module tb_rom_word_fetcher;
  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rom_en;
  logic [6:0] req_addr = '0, rom_addr;
  logic [15:0] rsp_data;
  logic [7:0] rom_data;
  logic req4_valid = 1'b0, req4_ready, rsp4_valid, rom4_en;
  logic [6:0] req4_addr = '0, rom4_addr;
  logic [31:0] rsp4_data;
  logic [7:0] rom4_data;
  logic [7:0] mem [128];
  logic [15:0] expq [$];
  int cyc = 0, rsp_cnt = 0, n_checks = 0, n_pass = 0;
  typedef struct {logic [6:0] addr; logic [15:0] exp;} vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_word_fetcher #(.ADDR_W(7), .DATA_W(8), .WORD_BYTES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .rom_enable(rom_en), .rom_addr(rom_addr), .rom_data(rom_data));
  rom_word_fetcher #(.ADDR_W(7), .DATA_W(8), .WORD_BYTES(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req4_valid), .req_addr(req4_addr), .req_ready(req4_ready),
    .rsp_valid(rsp4_valid), .rsp_data(rsp4_data), .rsp_ready(1'b1),
    .rom_enable(rom4_en), .rom_addr(rom4_addr), .rom_data(rom4_data));

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h41; mem[1] = 8'h53; mem[2] = 8'h52; mem[3] = 8'h4D; mem[127] = 8'h00;
  end
  always_ff @(posedge clk) begin
    rom_data  <= rom_en ? mem[rom_addr] : 8'h00;
    rom4_data <= rom4_en ? mem[rom4_addr] : 8'h00;
  end

  function automatic logic [15:0] exp_word(input logic [6:0] a);
    logic [6:0] b;
    b = a + 7'd1;
    return {mem[b], mem[a]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [6:0] a, input logic [15:0] e, input bit push, output int acc);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && n < 64) begin tick(); n++; end
    chk("req_accept", 64'(req_ready), 64'd1);
    tick();
    acc = cyc;
    if (push) expq.push_back(e);
  endtask

  task automatic wait_rsp();
    int s = rsp_cnt;
    int n = 0;
    while (rsp_cnt == s && n < 40) begin tick(); n++; end
    chk("rsp_arrival", 64'(rsp_cnt != s), 64'd1);
  endtask

  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (expq.size() == 0) chk("rsp_unexpected", 64'(rsp_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("rsp_data", 64'(rsp_data), 64'(expq.pop_front()));
      rsp_cnt <= rsp_cnt + 1;
    end
  end

  initial begin
    int acc, prev, n;
    vecs[0] = '{7'h00, 16'h5341};
    vecs[1] = '{7'h02, 16'h4D52};
    vecs[2] = '{7'h01, 16'h5253};
    vecs[3] = '{7'h03, 16'hA14D};
    vecs[4] = '{7'h10, 16'hB4B5};
    vecs[5] = '{7'h40, 16'hE4E5};
    vecs[6] = '{7'h7F, 16'h4100};
    repeat (2) tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rom_en", 64'(rom_en), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    reset = 1'b1;
    chk("rel_req_ready_low", 64'(req_ready), 64'd0);
    tick();
    chk("rel_req_ready_high", 64'(req_ready), 64'd1);

    rsp_ready = 1'b1;
    do_req(7'h00, 16'h5341, 1'b1, acc);
    req_valid = 1'b0;
    chk("b_en_c1", 64'(rom_en), 64'd1);
    chk("b_addr_c1", 64'(rom_addr), 64'h00);
    chk("b_valid_c1", 64'(rsp_valid), 64'd0);
    tick();
    chk("b_en_c2", 64'(rom_en), 64'd1);
    chk("b_addr_c2", 64'(rom_addr), 64'h01);
    tick();
    chk("b_en_c3", 64'(rom_en), 64'd1);
    chk("b_addr_hold", 64'(rom_addr), 64'h01);
    chk("b_partial", 64'(rsp_data), 64'h0041);
    chk("b_valid_c3", 64'(rsp_valid), 64'd0);
    tick();
    chk("b_valid_rsp", 64'(rsp_valid), 64'd1);
    chk("b_en_rsp", 64'(rom_en), 64'd0);
    chk("b_word", 64'(rsp_data), 64'h5341);
    chk("b_ready_rsp", 64'(req_ready), 64'd0);
    tick();
    chk("b_valid_after", 64'(rsp_valid), 64'd0);
    chk("b_ready_after", 64'(req_ready), 64'd1);

    rsp_ready = 1'b0;
    do_req(7'h02, 16'h4D52, 1'b1, acc);
    req_valid = 1'b0;
    repeat (3) tick();
    req_valid = 1'b1;
    req_addr  = 7'h10;
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_data", 64'(rsp_data), 64'h4D52);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rom_en", 64'(rom_en), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_valid_clr", 64'(rsp_valid), 64'd0);
    chk("bp_ready_back", 64'(req_ready), 64'd1);
    chk("bp_not_yet", 64'(rom_en), 64'd0);
    expq.push_back(16'hB4B5);
    tick();
    chk("bp_accept_en", 64'(rom_en), 64'd1);
    chk("bp_accept_addr", 64'(rom_addr), 64'h10);
    req_valid = 1'b0;
    wait_rsp();

    for (int v = 0; v < 7; v++) begin
      do_req(vecs[v].addr, vecs[v].exp, 1'b1, acc);
      req_valid = 1'b0;
      wait_rsp();
    end

    do_req(7'h7F, 16'h4100, 1'b1, acc);
    req_valid = 1'b0;
    chk("wrap_addr0", 64'(rom_addr), 64'h7F);
    tick();
    chk("wrap_addr1", 64'(rom_addr), 64'h00);
    wait_rsp();

    do_req(7'h00, 16'h0000, 1'b0, acc);
    req_valid = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_rom_en", 64'(rom_en), 64'd0);
    chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("ar_rsp_data", 64'(rsp_data), 64'd0);
    chk("ar_req_ready", 64'(req_ready), 64'd0);
    tick();
    #1 reset = 1'b1;
    chk("ar_rel_ready_low", 64'(req_ready), 64'd0);
    tick();
    chk("ar_rel_ready_high", 64'(req_ready), 64'd1);
    chk("ar_rel_data", 64'(rsp_data), 64'd0);
    do_req(7'h00, 16'h5341, 1'b1, acc);
    req_valid = 1'b0;
    wait_rsp();

    prev = 0;
    for (int k = 0; k < 8; k++) begin
      do_req(7'(2 * k), exp_word(7'(2 * k)), 1'b1, acc);
      if (k > 0) chk("b2b_period", 64'(acc - prev), 64'd5);
      prev = acc;
    end
    req_valid = 1'b0;
    n = 0;
    while (expq.size() != 0 && n < 40) begin tick(); n++; end
    chk("b2b_drain", 64'(expq.size()), 64'd0);

    chk("w4_ready", 64'(req4_ready), 64'd1);
    req4_valid = 1'b1;
    req4_addr  = 7'h00;
    tick();
    req4_valid = 1'b0;
    chk("w4_en_c1", 64'(rom4_en), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("w4_valid", 64'(rsp4_valid), 64'(k == 5));
      chk("w4_en", 64'(rom4_en), 64'(k < 5));
    end
    chk("w4_word", 64'(rsp4_data), 64'h4D525341);
    tick();
    chk("w4_valid_clr", 64'(rsp4_valid), 64'd0);
    chk("w4_ready_back", 64'(req4_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
